// File: rtl/idli_sqi_mem_if.sv
// idli_sqi_mem_if: SQI link signals between controller (master) and memory responder (slave)
interface idli_sqi_mem_if;
  typedef logic [3:0] sqi_data_t;
  logic      i_sqi_cs_n;
  sqi_data_t i_sqi_sio;
  sqi_data_t o_sqi_sio;
  logic      o_sqi_oe;
  modport master (output i_sqi_cs_n, output i_sqi_sio, input o_sqi_sio, input o_sqi_oe);
  modport slave (input i_sqi_cs_n, input i_sqi_sio, output o_sqi_sio, output o_sqi_oe);
endinterface

// File: rtl/idli_sqi_mem.sv
// idli_sqi_mem: SQI SRAM responder decoding READ/WRITE nibble streams into byte storage
module idli_sqi_mem #(
  parameter int DEPTH = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  idli_sqi_mem_if.slave        sqi
);
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic [2:0] {CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;
  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [3:0]          nib_q, nib_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                oe_q, oe_d;
  logic [3:0]          sio_q, sio_d;
  logic                wr_en;
  logic [ADDR_W-1:0]   addr_inc;
  logic [7:0]          cmd_byte;
  logic [7:0]          mem [DEPTH];
  assign addr_inc = addr_q + 1'b1;
  assign cmd_byte = {nib_q, sqi.i_sqi_sio};
  assign sqi.o_sqi_sio = sio_q;
  assign sqi.o_sqi_oe = oe_q;
  // Next-state and output decode; CS high returns everything to the command phase
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    nib_d = nib_q;
    rd_d = rd_q;
    addr_d = addr_q;
    oe_d = oe_q;
    sio_d = sio_q;
    wr_en = 1'b0;
    if (sqi.i_sqi_cs_n) begin
      state_d = CMD;
      cnt_d = 3'd0;
      phase_d = 1'b0;
      oe_d = 1'b0;
      sio_d = 4'd0;
    end else begin
      case (state_q)
        CMD: begin
          nib_d = sqi.i_sqi_sio;
          cnt_d = 3'd1;
          if (cnt_q != 3'd0) begin
            cnt_d = 3'd0;
            rd_d = cmd_byte == 8'h03;
            state_d = (cmd_byte == 8'h03 || cmd_byte == 8'h02) ? ADDR : IGNORE;
          end
        end
        ADDR: begin
          addr_d = ADDR_W'({addr_q, sqi.i_sqi_sio});
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            cnt_d = 3'd0;
            phase_d = 1'b0;
            state_d = rd_q ? DUMMY : WR_DATA;
          end
        end
        DUMMY: begin
          cnt_d = 3'd1;
          if (cnt_q != 3'd0) begin
            cnt_d = 3'd0;
            oe_d = 1'b1;
            sio_d = mem[addr_q][7:4];
            phase_d = 1'b0;
            state_d = RD_DATA;
          end
        end
        RD_DATA: begin
          phase_d = ~phase_q;
          addr_d = phase_q ? addr_inc : addr_q;
          sio_d = phase_q ? mem[addr_inc][7:4] : mem[addr_q][3:0];
        end
        WR_DATA: begin
          phase_d = ~phase_q;
          nib_d = phase_q ? nib_q : sqi.i_sqi_sio;
          addr_d = phase_q ? addr_inc : addr_q;
          wr_en = phase_q;
        end
        default: begin
          oe_d = 1'b0;
        end
      endcase
    end
  end
  // Control and output registers, cleared by async reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CMD;
      cnt_q <= 3'd0;
      phase_q <= 1'b0;
      nib_q <= 4'd0;
      rd_q <= 1'b0;
      addr_q <= '0;
      oe_q <= 1'b0;
      sio_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      nib_q <= nib_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      oe_q <= oe_d;
      sio_q <= sio_d;
    end
  end
  // Byte storage, not reset; writes only complete bytes while out of reset
  always_ff @(posedge i_clk) begin
    if (wr_en && i_rst_n) mem[addr_q] <= cmd_byte;
  end
endmodule

// File: tb/tb_idli_sqi_mem.sv
// tb_idli_sqi_mem: directed SQI transactions with a scoreboard of expected read nibbles
module tb_idli_sqi_mem;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] sb [$];
  idli_sqi_mem_if sqi ();
  idli_sqi_mem #(.DEPTH(1024)) dut (.i_clk(clk), .i_rst_n(rst_n), .sqi(sqi));
  always #5 clk = ~clk;

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    sqi.i_sqi_cs_n = 1'b0;
    sqi.i_sqi_sio = n;
  endtask

  task automatic idle();
    @(negedge clk);
    sqi.i_sqi_cs_n = 1'b1;
    sqi.i_sqi_sio = 4'd0;
    @(negedge clk);
  endtask

  task automatic hdr(input logic [7:0] c, input logic [23:0] a);
    nib(c[7:4]);
    nib(c[3:0]);
    for (int i = 5; i >= 0; i--) nib(a[i*4+:4]);
  endtask

  task automatic wr(input logic [23:0] a, input int nb, input logic [15:0] d);
    hdr(8'h02, a);
    for (int i = nb - 1; i >= 0; i--) begin
      nib(d[i*8+4+:4]);
      nib(d[i*8+:4]);
    end
    idle();
  endtask

  task automatic rd(input logic [23:0] a, input int nn, input logic [15:0] e);
    for (int i = nn - 1; i >= 0; i--) sb.push_back(e[i*4+:4]);
    hdr(8'h03, a);
    nib(4'h0);
    nib(4'h0);
    for (int i = 1; i < nn; i++) nib(4'h0);
    idle();
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every nibble the responder drives must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n && sqi.o_sqi_oe) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_oe: oe=1 sio=%h, expected oe=0", sqi.o_sqi_sio);
      end else begin
        automatic logic [3:0] e = sb.pop_front();
        if (sqi.o_sqi_sio !== e) begin
          n_fail++;
          $display("FAIL read_nibble: got %h, expected %h", sqi.o_sqi_sio, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    sqi.i_sqi_cs_n = 1'b1;
    sqi.i_sqi_sio = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_oe", {3'd0, sqi.o_sqi_oe}, 4'd0);
    chk("reset_sio", sqi.o_sqi_sio, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_oe", {3'd0, sqi.o_sqi_oe}, 4'd0);
    wr(24'h000010, 2, 16'hA53C);
    rd(24'h000010, 4, 16'hA53C);
    wr(24'h0003FF, 2, 16'h1122);
    rd(24'h000000, 2, 16'h0022);
    rd(24'h0003FF, 2, 16'h0011);
    rd(24'h0003FF, 4, 16'h1122);
    rd(24'h000410, 2, 16'h00A5);
    for (int i = 0; i < 12; i++) nib(4'hF);
    idle();
    rd(24'h000010, 4, 16'hA53C);
    hdr(8'h02, 24'h000010);
    nib(4'h7);
    idle();
    rd(24'h000010, 2, 16'h00A5);
    sb.push_back(4'hA);
    sb.push_back(4'h5);
    hdr(8'h03, 24'h000010);
    nib(4'h0);
    nib(4'h0);
    nib(4'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    sqi.i_sqi_cs_n = 1'b1;
    #1;
    chk("abort_oe", {3'd0, sqi.o_sqi_oe}, 4'd0);
    chk("abort_sio", sqi.o_sqi_sio, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(24'h0003FF, 2, 16'h0011);
    rd(24'h000011, 2, 16'h003C);
    repeat (4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d nibbles left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/idli_sqi_mem.md
Name: idli_sqi_mem

Overview:
- Synthesizable SQI SRAM responder: the memory end of the SQI link.
- One instance models one attached memory. The system instantiates SQI_NUM (2) of them, one holding low nibbles and one holding high nibbles.
- Used as the memory model in simulation and FPGA bring-up.
- Decodes the 4-bit-per-cycle serial command stream (READ/WRITE, 24-bit address) and returns or stores byte data with sequential address auto-increment.

Parameters:
- DEPTH, 1024: storage size in bytes; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH): internal address width (derived; not overridden).

Ports:
- i_clk  in  1  SQI clock; all sampling and driving on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sqi_cs_n  in  1  chip select, active low.
- i_sqi_sio  in  4  nibble from controller (type sqi_data_t).
- o_sqi_sio  out  4  nibble to controller (sqi_data_t), meaningful only while o_sqi_oe=1.
- o_sqi_oe  out  1  responder is driving o_sqi_sio.

Behaviour:
- Reset (async assert, sync deassert in surrounding logic): state=CMD, nibble count=0, o_sqi_oe=0, o_sqi_sio=0, address=0. Storage contents are not reset.
- Reset during any transfer aborts it immediately. A partially received byte is never written.
- Any edge sampling i_sqi_cs_n=1 forces state=CMD, count=0, o_sqi_oe=0, o_sqi_sio=0. A pending partial write nibble is discarded.
- All serial fields are MSB first: high nibble of each byte, then low nibble.
- Edges are numbered from the first edge with i_sqi_cs_n=0 (edge 0).
- CMD: edges 0–1 shift in the 8-bit instruction. At edge 1 decode it:
  - 0x03 → ADDR (read)
  - 0x02 → ADDR (write)
  - anything else → IGNORE
- ADDR: edges 2–7 shift in 24 address bits. Only the low ADDR_W bits are kept; upper bits are ignored, so addressing is modulo DEPTH. At edge 7: read → DUMMY, write → WR_DATA.
- DUMMY (read only): edges 8–9, one dummy byte; the input is ignored.
  - At edge 9, o_sqi_oe←1 and o_sqi_sio←mem[A][7:4]. This is valid for the controller to sample at edge 10.
- RD_DATA, each following edge:
  - Odd phase: o_sqi_sio←mem[A][3:0].
  - Even phase: A←(A+1) mod DEPTH and o_sqi_sio←mem[A+1][7:4].
  - Streams indefinitely until CS deasserts.
  - Read data is a registered output with 1-cycle latency from the edge that selects it.
- WR_DATA: edge 8 latches the high nibble; edge 9 writes {hi, i_sqi_sio} to mem[A] and A←(A+1) mod DEPTH. The two-edge pattern repeats until CS deasserts.
- IGNORE: o_sqi_oe=0, no storage change, held until CS deasserts.
- Wrap-around: address DEPTH-1 increments to 0 for both read and write.
- Read-after-write in a new transaction returns the new data. No read-during-write hazard exists within a single transaction.
- o_sqi_oe is never asserted in CMD, ADDR, WR_DATA or IGNORE, or in the first DUMMY cycle.
- Internal state encoding: CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE, plus a 3-bit nibble counter and a 1-bit byte phase.

Test Plan:
- Basic write/read:
  - CS low, send nibbles 0,2,0,0,0,0,1,0,A,5,3,C, then CS high.
  - New transaction: 0,3,0,0,0,0,1,0 plus 2 dummy nibbles.
  - → o_sqi_oe=1 from edge 9; sampled nibbles at edges 10–13 = A,5,3,C.
- Wrap (DEPTH=1024):
  - Write 0x11,0x22 starting at address 0x0003FF.
  - Read from 0x000000 → 2,2; read from 0x0003FF → 1,1.
- Address aliasing: read at 0x000410 returns the same bytes as 0x000010 (A,5).
- Illegal command:
  - Send instruction 0xFF, then 10 further nibbles of 0xF, then CS high.
  - → o_sqi_oe stays 0 throughout; a subsequent read of 0x10 is still A,5,3,C.
- Abort:
  - Write to 0x10 with only one data nibble (0x7), then CS high → mem[0x10] remains 0xA5.
  - Mid-read, pull i_rst_n low → o_sqi_oe=0 and o_sqi_sio=0 immediately; the next transaction decodes normally from CMD.
